// File: rtl/add_round_key_stage_if.sv
// Stream and key-load signals of the AddRoundKey stage.
// slave is the stage's own view; master is the view of whoever drives it.
interface add_round_key_stage_if;
    // Round-key loading
    logic         key_wr_en;
    logic [3:0]   key_wr_idx;
    logic [127:0] key_wr_data;
    logic         key_clr;
    logic         keys_ready;

    // Upstream beat (from MixColumns, or the final-round bypass)
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_state;
    logic [3:0]   in_round;
    logic         in_last;

    // Downstream beat
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_state;
    logic [3:0]   out_round;
    logic         out_last;

    // Sticky out-of-range round indication
    logic         err_round;

    modport slave (
        input  key_wr_en, key_wr_idx, key_wr_data, key_clr,
        input  in_valid, in_state, in_round, in_last,
        input  out_ready,
        output keys_ready, in_ready,
        output out_valid, out_state, out_round, out_last,
        output err_round
    );

    modport master (
        output key_wr_en, key_wr_idx, key_wr_data, key_clr,
        output in_valid, in_state, in_round, in_last,
        output out_ready,
        input  keys_ready, in_ready,
        input  out_valid, out_state, out_round, out_last,
        input  err_round
    );
endinterface

// File: rtl/add_round_key_stage.sv
// AES AddRoundKey pipeline stage.
// Each accepted beat is XORed with the round key picked by its round tag and
// queued in a two-entry skid buffer (head register drives the outputs, skid
// register absorbs one extra beat under backpressure). in_ready is registered
// and never looks at out_ready combinationally.
module add_round_key_stage #(
    parameter int NUM_ROUNDS = 10
) (
    input logic                  clk,
    input logic                  rst,
    add_round_key_stage_if.slave bus
);

    localparam logic [3:0] MAX_ROUND = 4'(NUM_ROUNDS);

    typedef struct packed {
        logic [127:0] state;
        logic [3:0]   round;
        logic         last;
    } beat_t;

    logic [127:0]      key_mem [NUM_ROUNDS+1];
    logic [NUM_ROUNDS:0] loaded;
    logic              keys_ready_q;
    logic              in_ready_q;
    logic              err_q;
    logic [1:0]        occ_q;
    beat_t             head_q;
    beat_t             skid_q;

    logic              key_wr_ok;
    logic              round_ok;
    logic [127:0]      round_key;
    logic              push;
    logic              pop;
    logic [1:0]        occ_d;
    beat_t             in_beat;

    // Key selection, handshakes and next occupancy.
    // NOTE: every signal gets a value on every path through this block, so no latch is inferred.
    always_comb begin
        key_wr_ok = bus.key_wr_en && (bus.key_wr_idx <= MAX_ROUND);
        round_ok  = (bus.in_round <= MAX_ROUND);
        round_key = '0;
        if (round_ok) begin
            round_key = key_mem[bus.in_round];
        end
        push          = bus.in_valid && in_ready_q;
        pop           = (occ_q != 2'd0) && bus.out_ready;
        occ_d         = occ_q + {1'b0, push} - {1'b0, pop};
        in_beat.state = bus.in_state ^ round_key;
        in_beat.round = bus.in_round;
        in_beat.last  = bus.in_last;
    end

    // Round-key storage; a beat reading the same index this cycle still sees the old key.
    // NOTE: key contents carry no reset; only their loaded flags do, which is what gates use.
    always_ff @(posedge clk) begin
        if (key_wr_ok) begin
            key_mem[bus.key_wr_idx] <= bus.key_wr_data;
        end
    end

    // Loaded flags, registered readiness, occupancy and the sticky round error.
    // NOTE: state registers use non-blocking assignments so every block sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst) begin
            loaded       <= '0;
            keys_ready_q <= 1'b0;
            in_ready_q   <= 1'b0;
            err_q        <= 1'b0;
            occ_q        <= 2'd0;
        end else begin
            if (bus.key_clr) begin
                loaded <= '0;
            end else if (key_wr_ok) begin
                loaded[bus.key_wr_idx] <= 1'b1;
            end
            keys_ready_q <= &loaded;
            in_ready_q   <= (&loaded) && (occ_d < 2'd2);
            if (push && !round_ok) begin
                err_q <= 1'b1;
            end
            occ_q <= occ_d;
        end
    end

    // Head entry: refilled from the skid slot when full, else straight from the input.
    always_ff @(posedge clk) begin
        if (!rst) begin
            head_q <= '0;
        end else if (pop && (occ_q == 2'd2)) begin
            head_q <= skid_q;
        end else if (push && ((occ_q == 2'd0) || pop)) begin
            head_q <= in_beat;
        end
    end

    // Skid entry: holds the second beat while the head is stalled.
    always_ff @(posedge clk) begin
        if (push && (((occ_q == 2'd1) && !pop) || ((occ_q == 2'd2) && pop))) begin
            skid_q <= in_beat;
        end
    end

    assign bus.keys_ready = keys_ready_q;
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (occ_q != 2'd0);
    assign bus.out_state  = head_q.state;
    assign bus.out_round  = head_q.round;
    assign bus.out_last   = head_q.last;
    assign bus.err_round  = err_q;

endmodule

// File: tb/tb_add_round_key_stage.sv
// Self-checking bench for add_round_key_stage: directed vector table,
// hand-written multi-cycle sequences and randomized traffic against a
// queue-based reference model.
module tb_add_round_key_stage;

    localparam int NR = 10;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    add_round_key_stage_if bus();

    add_round_key_stage #(.NUM_ROUNDS(NR)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct {
        logic [127:0] state;
        logic [3:0]   round;
        logic         last;
    } exp_t;

    logic [127:0] model_key [NR+1];
    exp_t         exp_q [$];
    int           pops = 0;
    logic         hold_prev = 1'b0;
    logic [127:0] held_state;
    logic [3:0]   held_round;
    logic         held_last;

    function automatic logic [127:0] ref_out(input logic [127:0] s, input logic [3:0] r);
        logic [127:0] k;
        logic [127:0] o;
        k = (int'(r) <= NR) ? model_key[r] : '0;
        for (int b = 0; b < 16; b++) begin
            o[8*b +: 8] = s[8*b +: 8] ^ k[8*b +: 8];
        end
        return o;
    endfunction

    // Observe handshakes at the falling edge, where everything is stable for the next rising edge.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (!rst) begin
            exp_q.delete();
            hold_prev = 1'b0;
        end else begin
            if (hold_prev) begin
                check("hold_state", bus.out_state, held_state);
                check("hold_round", bus.out_round, held_round);
                check("hold_last",  bus.out_last,  held_last);
            end
            if (exp_q.size() != 0) begin
                check("latency_valid", bus.out_valid, 1'b1);
            end
            if (bus.out_valid && bus.out_ready) begin
                check("out_has_ref", 128'(exp_q.size() != 0), 1'b1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    check("sb_state", bus.out_state, e.state);
                    check("sb_round", bus.out_round, e.round);
                    check("sb_last",  bus.out_last,  e.last);
                    pops++;
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                e.state = ref_out(bus.in_state, bus.in_round);
                e.round = bus.in_round;
                e.last  = bus.in_last;
                exp_q.push_back(e);
            end
            hold_prev  = bus.out_valid && !bus.out_ready;
            held_state = bus.out_state;
            held_round = bus.out_round;
            held_last  = bus.out_last;
        end
        // Key writes take effect at the coming edge, after this cycle's beat used the old key.
        if (bus.key_wr_en && int'(bus.key_wr_idx) <= NR) begin
            model_key[bus.key_wr_idx] = bus.key_wr_data;
        end
    end

    // ---------------- helpers ----------------
    function automatic logic [127:0] bswap(input logic [127:0] v);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) begin
            r[8*i +: 8] = v[8*(15-i) +: 8];
        end
        return r;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_key(input logic [3:0] idx, input logic [127:0] data);
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = idx;
        bus.key_wr_data = data;
        tick();
        bus.key_wr_en   = 1'b0;
    endtask

    // Present one beat and hold it until accepted (bounded).
    task automatic send(input logic [127:0] s, input logic [3:0] r, input logic l);
        int n;
        n = 0;
        bus.in_valid = 1'b1;
        bus.in_state = s;
        bus.in_round = r;
        bus.in_last  = l;
        while (!bus.in_ready && n < 50) begin
            tick();
            n++;
        end
        if (n == 50) check("send_timeout", bus.in_ready, 1'b1);
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_out_valid"},  bus.out_valid,  1'b0);
        check({tag, "_in_ready"},   bus.in_ready,   1'b0);
        check({tag, "_keys_ready"}, bus.keys_ready, 1'b0);
        check({tag, "_err_round"},  bus.err_round,  1'b0);
        check({tag, "_out_state"},  bus.out_state,  '0);
        check({tag, "_out_round"},  bus.out_round,  '0);
        check({tag, "_out_last"},   bus.out_last,   1'b0);
    endtask

    typedef struct {
        logic [127:0] state;
        logic [3:0]   round;
        logic         last;
        logic [127:0] exp_state;
        logic         exp_err;
    } vec_t;

    vec_t vt [6];
    logic [127:0] fips_key;
    logic [127:0] s1, s2, old3;
    logic acc;
    int sent, pops0;

    initial begin
        bus.key_wr_en   = 1'b0;
        bus.key_wr_idx  = '0;
        bus.key_wr_data = '0;
        bus.key_clr     = 1'b0;
        bus.in_valid    = 1'b0;
        bus.in_state    = '0;
        bus.in_round    = '0;
        bus.in_last     = 1'b0;
        bus.out_ready   = 1'b1;

        fips_key = bswap(128'h2b7e151628aed2a6abf7158809cf4f3c);
        vt[0] = '{bswap(128'h3243f6a8885a308d313198a2e0370734), 4'd0,  1'b0,
                  bswap(128'h193de3bea0f4e22b9ac68d2ae9f84808), 1'b0};
        vt[1] = '{bswap(128'h00112233445566778899aabbccddeeff), 4'd7,  1'b1,
                  bswap(128'h00112233445566778899aabbccddeeff), 1'b0};
        vt[2] = '{{128{1'b1}},                                   4'd0,  1'b0,
                  bswap(128'hd481eae9d7512d595408ea77f630b0c3), 1'b0};
        vt[3] = '{128'hcafef00d_deadbeef_01020304_a5a55a5a,      4'd10, 1'b1,
                  128'hcafef00d_deadbeef_01020304_a5a55a5a,      1'b0};
        vt[4] = '{128'h0f0e0d0c_0b0a0908_07060504_03020100,      4'd11, 1'b0,
                  128'h0f0e0d0c_0b0a0908_07060504_03020100,      1'b1};
        vt[5] = '{bswap(128'h0123456789abcdef0123456789abcdef), 4'd12, 1'b1,
                  bswap(128'h0123456789abcdef0123456789abcdef), 1'b1};

        // Reset state
        repeat (3) tick();
        check_reset_outputs("reset");
        rst = 1'b1;
        tick();

        // Load FIPS key at 0, zeros elsewhere; keys_ready follows the last write by one cycle
        write_key(4'd0, fips_key);
        for (int i = 1; i <= NR; i++) write_key(4'(i), '0);
        check("load_keys_ready_lag", bus.keys_ready, 1'b0);
        tick();
        check("load_keys_ready", bus.keys_ready, 1'b1);
        check("load_in_ready",   bus.in_ready,   1'b1);

        // Directed vector table, one beat at a time with one-cycle latency
        for (int i = 0; i < 6; i++) begin
            send(vt[i].state, vt[i].round, vt[i].last);
            check($sformatf("vec%0d_valid", i), bus.out_valid, 1'b1);
            check($sformatf("vec%0d_state", i), bus.out_state, vt[i].exp_state);
            check($sformatf("vec%0d_round", i), bus.out_round, vt[i].round);
            check($sformatf("vec%0d_last", i),  bus.out_last,  vt[i].last);
            check($sformatf("vec%0d_err", i),   bus.err_round, vt[i].exp_err);
        end
        tick();

        // Random keys for the remaining tests
        for (int i = 0; i <= NR; i++) write_key(4'(i), rnd128());
        repeat (2) tick();

        // Streaming: 20 back-to-back beats, outputs on consecutive cycles
        pops0 = pops;
        for (int i = 0; i < 20; i++) begin
            bus.in_valid = 1'b1;
            bus.in_state = rnd128();
            bus.in_round = 4'(i % 11);
            bus.in_last  = (i == 19);
            check("stream_in_ready", bus.in_ready, 1'b1);
            tick();
            check("stream_out_valid", bus.out_valid, 1'b1);
        end
        bus.in_valid = 1'b0;
        tick();
        check("stream_count", 128'(pops - pops0), 128'd20);

        // Backpressure: stall 5 cycles, buffer fills to two, then drain
        pops0 = pops;
        sent  = 0;
        bus.out_ready = 1'b0;
        bus.in_state  = rnd128();
        bus.in_round  = 4'd0;
        bus.in_last   = 1'b0;
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            acc = bus.in_ready;
            tick();
            if (acc) begin
                sent++;
                bus.in_state = rnd128();
                bus.in_round = 4'(sent % 11);
            end
        end
        check("bp_in_ready",  bus.in_ready,  1'b0);
        check("bp_out_valid", bus.out_valid, 1'b1);
        check("bp_accepted",  128'(sent),    128'd2);
        bus.out_ready = 1'b1;
        for (int c = 0; c < 40 && sent < 8; c++) begin
            bus.in_valid = 1'b1;
            acc = bus.in_ready;
            tick();
            if (acc) begin
                sent++;
                bus.in_state = rnd128();
                bus.in_round = 4'(sent % 11);
            end
        end
        bus.in_valid = 1'b0;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("bp_sent",      128'(sent),         128'd8);
        check("bp_delivered", 128'(pops - pops0), 128'd8);

        // Key race: write key 3 while accepting a round-3 beat
        old3 = model_key[3];
        s1   = rnd128();
        s2   = rnd128();
        bus.in_valid    = 1'b1;
        bus.in_state    = s1;
        bus.in_round    = 4'd3;
        bus.key_wr_en   = 1'b1;
        bus.key_wr_idx  = 4'd3;
        bus.key_wr_data = {128{1'b1}};
        check("race_in_ready", bus.in_ready, 1'b1);
        tick();
        bus.key_wr_en = 1'b0;
        bus.in_valid  = 1'b0;
        check("race_old_key", bus.out_state, s1 ^ old3);
        send(s2, 4'd3, 1'b0);
        check("race_new_key", bus.out_state, ~s2);
        tick();

        // Randomized traffic with occasional key writes (some to ignored indices)
        for (int c = 0; c < 80; c++) begin
            bus.in_valid    = ($urandom % 4) != 0;
            bus.in_state    = rnd128();
            bus.in_round    = 4'($urandom_range(0, NR));
            bus.in_last     = 1'($urandom % 2);
            bus.out_ready   = ($urandom % 3) != 0;
            bus.key_wr_en   = ($urandom % 8) == 0;
            bus.key_wr_idx  = 4'($urandom_range(0, 15));
            bus.key_wr_data = rnd128();
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.key_wr_en = 1'b0;
        bus.out_ready = 1'b1;
        for (int c = 0; c < 10 && exp_q.size() != 0; c++) tick();
        check("rand_drained", 128'(exp_q.size()), 128'd0);
        check("rand_keys_ready", bus.keys_ready, 1'b1);

        // key_clr with two beats buffered: both drain, new beats blocked
        bus.out_ready = 1'b0;
        send(rnd128(), 4'd1, 1'b0);
        send(rnd128(), 4'd2, 1'b1);
        check("clr_full_in_ready", bus.in_ready, 1'b0);
        pops0 = pops;
        bus.key_clr = 1'b1;
        tick();
        bus.key_clr = 1'b0;
        check("clr_keys_ready_lag", bus.keys_ready, 1'b1);
        tick();
        check("clr_keys_ready", bus.keys_ready, 1'b0);
        check("clr_in_ready",   bus.in_ready,   1'b0);
        check("clr_err_sticky", bus.err_round,  1'b1);
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_state  = rnd128();
        bus.in_round  = 4'd0;
        repeat (3) tick();
        check("clr_drained",       128'(pops - pops0),  128'd2);
        check("clr_out_valid",     bus.out_valid,       1'b0);
        check("clr_blocked",       128'(exp_q.size()),  128'd0);
        check("clr_blocked_ready", bus.in_ready,        1'b0);

        // Rewrite all keys; the first write coincides with key_clr, which wins for its flag
        bus.key_clr = 1'b1;
        write_key(4'd0, rnd128());
        bus.key_clr = 1'b0;
        for (int i = 1; i <= NR; i++) write_key(4'(i), rnd128());
        tick();
        check("clr_wins_flags", bus.keys_ready, 1'b0);
        check("clr_wins_ready", bus.in_ready,   1'b0);
        write_key(4'd0, rnd128());
        tick();
        check("reload_keys_ready", bus.keys_ready, 1'b1);
        check("reload_in_ready",   bus.in_ready,   1'b1);
        bus.in_valid = 1'b0;
        tick();

        // Reset mid-operation discards buffered beats
        bus.out_ready = 1'b0;
        send(rnd128(), 4'd4, 1'b0);
        send(rnd128(), 4'd5, 1'b1);
        check("mid_out_valid_before", bus.out_valid, 1'b1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        check_reset_outputs("mid_rst");
        bus.out_ready = 1'b1;
        tick();
        check("mid_rst_no_output", bus.out_valid, 1'b0);
        check("mid_rst_keys",      bus.keys_ready, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global watchdog so the run always terminates.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
